// File: rtl/led_dimmer_if.sv
// Pattern-word handshake between the upstream counter stage and led_dimmer.
// The master drives din/din_valid; the slave returns din_ready.
interface led_dimmer_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/led_dimmer.sv
// PWM LED dimmer: buffers one pattern word and swaps it in, together with the brightness level, only at PWM period boundaries.
// Optional macro LED_DIMMER_GAMMA_EN selects a squared (gamma) brightness curve.
//
// state  | meaning
// S_IDLE | ready for a new word (din_ready=1)
// S_HOLD | word captured in r_pend, waiting for the next period boundary
module led_dimmer #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  led_dimmer_if.slave  s_din,
  input  logic [7:0]   i_bright,
  output logic         o_led0,
  output logic         o_led1,
  output logic         o_led2,
  output logic         o_led3,
  output logic         o_led4,
  output logic         o_led5,
  output logic         o_led6,
  output logic         o_led7
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_tick;
  logic        w_pb;
  logic        w_ready;
  logic        w_accept;
  logic        w_load_show;
  logic        w_lit;
  logic [7:0]  w_eff;
  logic [7:0]  r_pwm;
  logic [7:0]  r_pend;
  logic [7:0]  r_show;
  logic [7:0]  r_lvl;
  logic [7:0]  r_led;

  if (N == 0) begin : g_no_presc
    assign w_tick = 1'b1;
  end else begin : g_presc
    logic [N-1:0] r_presc;

    always_ff @(posedge i_clk) begin
      if (i_rst) r_presc <= '0;
      else       r_presc <= r_presc + 1'b1;
    end

    assign w_tick = &r_presc;
  end

  assign w_pb = w_tick && (r_pwm == 8'hFF);

`ifdef LED_DIMMER_GAMMA_EN
  // full scale stays full scale so LVL=255 keeps its no-off-slot meaning
  assign w_eff = (i_bright == 8'hFF) ? 8'hFF
                                     : 8'((16'(i_bright) * 16'(i_bright)) >> 8);
`else
  assign w_eff = i_bright;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_load_show = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (s_din.din_valid) begin
          w_accept = 1'b1;
          w_next   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_pb) begin
          w_load_show = 1'b1;
          w_next      = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign s_din.din_ready = w_ready;

  assign w_lit = (r_lvl == 8'hFF) || (r_pwm < r_lvl);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm  <= '0;
      r_pend <= '0;
      r_show <= '0;
      r_lvl  <= '0;
      r_led  <= '0;
    end else begin
      if (w_tick)      r_pwm  <= r_pwm + 8'd1;
      if (w_accept)    r_pend <= s_din.din;
      if (w_load_show) r_show <= r_pend;
      if (w_pb)        r_lvl  <= w_eff;
      r_led <= r_show & {8{w_lit}};
    end
  end

  assign o_led0 = r_led[0];
  assign o_led1 = r_led[1];
  assign o_led2 = r_led[2];
  assign o_led3 = r_led[3];
  assign o_led4 = r_led[4];
  assign o_led5 = r_led[5];
  assign o_led6 = r_led[6];
  assign o_led7 = r_led[7];

endmodule

// File: tb/tb_led_dimmer.sv
// Directed bench for led_dimmer: one N=0 instance for most scenarios, one N=2 instance for prescaled period spacing.
module tb_led_dimmer;

  logic       clk = 1'b0;
  logic       rst0, rst2;
  logic [7:0] br0, br2;
  wire  [7:0] leds0, leds2;

  int n_cmp = 0;
  int n_err = 0;
  int pw0, pr2, pw2;
  int bad, t, k, ones;
  logic [7:0] exp_led;

  led_dimmer_if if0 ();
  led_dimmer_if if2 ();

  always #5 clk = ~clk;

  led_dimmer #(.N(0)) u0 (
    .i_clk(clk), .i_rst(rst0), .s_din(if0), .i_bright(br0),
    .o_led0(leds0[0]), .o_led1(leds0[1]), .o_led2(leds0[2]), .o_led3(leds0[3]),
    .o_led4(leds0[4]), .o_led5(leds0[5]), .o_led6(leds0[6]), .o_led7(leds0[7])
  );

  led_dimmer #(.N(2)) u2 (
    .i_clk(clk), .i_rst(rst2), .s_din(if2), .i_bright(br2),
    .o_led0(leds2[0]), .o_led1(leds2[1]), .o_led2(leds2[2]), .o_led3(leds2[3]),
    .o_led4(leds2[4]), .o_led5(leds2[5]), .o_led6(leds2[6]), .o_led7(leds2[7])
  );

  function automatic int eff(input int b);
`ifdef LED_DIMMER_GAMMA_EN
    return (b == 255) ? 255 : ((b * b) >> 8);
`else
    return b;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; pw0/pr2/pw2 track the expected PWM/prescaler values seen at each negedge.
  task automatic nclk(input int n);
    for (int i = 0; i < n; i++) begin
      logic r0, r2;
      r0 = rst0;
      r2 = rst2;
      @(negedge clk);
      pw0 = r0 ? 0 : ((pw0 + 1) & 255);
      if (r2) begin
        pr2 = 0;
        pw2 = 0;
      end else begin
        if (pr2 == 3) pw2 = (pw2 + 1) & 255;
        pr2 = (pr2 + 1) & 3;
      end
    end
  endtask

  // Measure one full period of LED0 bank after lvl has taken effect.
  task automatic measure_duty(input string tag, input int lvl);
    bad = 0;
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      exp_led = ((((pw0 + 255) & 255) < lvl) || (lvl == 255)) ? 8'hFF : 8'h00;
      if (leds0 !== exp_led) bad++;
      if (leds0 === 8'hFF) ones++;
      nclk(1);
    end
    check({tag, "_shape"}, bad, 0);
    check({tag, "_count"}, ones, lvl);
  endtask

  initial begin
    rst0 = 1'b1; rst2 = 1'b1;
    br0 = 8'd0;  br2 = 8'd0;
    if0.din = 8'h00; if0.din_valid = 1'b0;
    if2.din = 8'h00; if2.din_valid = 1'b0;
    pw0 = 0; pr2 = 0; pw2 = 0;

    // reset and idle
    nclk(3);
    rst0 = 1'b0;
    nclk(1);
    check("rst_leds", leds0, 8'h00);
    check("rst_ready", if0.din_ready, 1'b1);
    bad = 0;
    repeat (600) begin
      nclk(1);
      if (if0.din_ready !== 1'b1 || leds0 !== 8'h00) bad++;
    end
    check("idle_600", bad, 0);

    // accept 0xA5 at full brightness
    br0 = 8'd255;
    if0.din = 8'hA5; if0.din_valid = 1'b1;
    nclk(1);
    if0.din_valid = 1'b0; if0.din = 8'h00;
    check("hold_ready_low", if0.din_ready, 1'b0);
    bad = 0; t = 0;
    while (pw0 != 255 && t < 300) begin
      if (if0.din_ready !== 1'b0 || leds0 !== 8'h00) bad++;
      nclk(1); t++;
    end
    check("pb1_reached", t < 300, 1'b1);
    check("hold_quiet", bad, 0);
    nclk(1);
    check("ready_after_pb", if0.din_ready, 1'b1);
    check("led_not_early", leds0, 8'h00);
    nclk(1);
    check("led_a5", leds0, 8'hA5);
    bad = 0;
    repeat (300) begin
      nclk(1);
      if (leds0 !== 8'hA5) bad++;
    end
    check("a5_steady", bad, 0);

    // accept on the same cycle as a period boundary waits a full period
    t = 0;
    while (pw0 != 255 && t < 300) begin nclk(1); t++; end
    check("pb2_reached", t < 300, 1'b1);
    if0.din = 8'h42; if0.din_valid = 1'b1;
    nclk(1);
    if0.din_valid = 1'b0; if0.din = 8'h00;
    check("pb_accept_hold", if0.din_ready, 1'b0);
    bad = 0; t = 0;
    while (pw0 != 255 && t < 300) begin
      if (leds0 !== 8'hA5 || if0.din_ready !== 1'b0) bad++;
      nclk(1); t++;
    end
    check("pb3_reached", t < 300, 1'b1);
    check("pb_accept_waits", bad, 0);
    nclk(2);
    check("led_42", leds0, 8'h42);

    // 0xFF at brightness 64
    if0.din = 8'hFF; if0.din_valid = 1'b1;
    nclk(1);
    if0.din_valid = 1'b0; if0.din = 8'h00;
    br0 = 8'd64;
    t = 0;
    while (pw0 != 255 && t < 300) begin nclk(1); t++; end
    check("pb4_reached", t < 300, 1'b1);
    nclk(2);
    measure_duty("duty64", eff(64));

    // brightness 0, then 200 requested mid-period
    br0 = 8'd0;
    t = 0;
    while (pw0 != 255 && t < 300) begin nclk(1); t++; end
    check("pb5_reached", t < 300, 1'b1);
    nclk(2);
    bad = 0;
    repeat (100) begin
      if (leds0 !== 8'h00) bad++;
      nclk(1);
    end
    br0 = 8'd200;
    t = 0;
    while (pw0 != 255 && t < 300) begin
      if (leds0 !== 8'h00) bad++;
      nclk(1); t++;
    end
    check("pb6_reached", t < 300, 1'b1);
    nclk(1);
    if (leds0 !== 8'h00) bad++;
    check("lvl0_dark", bad, 0);
    nclk(1);
    measure_duty("duty200", eff(200));

    // reset during HOLD discards 0x3C and dominates din_valid
    check("idle_before_3c", if0.din_ready, 1'b1);
    if0.din = 8'h3C; if0.din_valid = 1'b1;
    nclk(1);
    if0.din = 8'h81;
    check("hold_3c", if0.din_ready, 1'b0);
    nclk(5);
    rst0 = 1'b1;
    nclk(1);
    rst0 = 1'b0;
    if0.din_valid = 1'b0;
    check("rst_hold_ready", if0.din_ready, 1'b1);
    check("rst_hold_leds", leds0, 8'h00);
    br0 = 8'd255;
    bad = 0;
    repeat (600) begin
      nclk(1);
      if (leds0 !== 8'h00 || if0.din_ready !== 1'b1) bad++;
    end
    check("3c_never_shown", bad, 0);

    // N=2: word presented during HOLD is dropped; boundaries 1024 clocks apart
    rst2 = 1'b0;
    nclk(1);
    check("n2_rst_ready", if2.din_ready, 1'b1);
    check("n2_rst_leds", leds2, 8'h00);
    br2 = 8'd255;
    if2.din = 8'h0F; if2.din_valid = 1'b1;
    nclk(1);
    if2.din = 8'hF0;
    check("n2_hold", if2.din_ready, 1'b0);
    nclk(1);
    if2.din_valid = 1'b0; if2.din = 8'h00;
    bad = 0; t = 0;
    while (!(pr2 == 3 && pw2 == 255) && t < 1100) begin
      if (leds2 !== 8'h00) bad++;
      nclk(1); t++;
    end
    check("n2_pb_reached", t < 1100, 1'b1);
    check("n2_dark_before_pb", bad, 0);
    nclk(1);
    check("n2_led_not_early", leds2, 8'h00);
    check("n2_ready_after_pb", if2.din_ready, 1'b1);
    nclk(1);
    check("n2_led_0f", leds2, 8'h0F);
    if2.din = 8'h55; if2.din_valid = 1'b1;
    nclk(1);
    if2.din_valid = 1'b0; if2.din = 8'h00;
    k = 1;
    while (leds2 === 8'h0F && k < 1100) begin nclk(1); k++; end
    check("n2_pb_spacing", k, 1024);
    check("n2_led_55", leds2, 8'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_dimmer.md
LED_DIMMER -- requirements
Module: led_dimmer

Interface
- REQ-001 Parameter N, default 4: PWM prescaler bits; PWM counter advances once every 2^N CLK cycles; legal range 0..20.
- REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
- REQ-003 RST  input  1  synchronous, active-high reset.
- REQ-004 DIN  input  8  LED pattern word from the upstream 8-bit counter stage; bit i drives LEDi.
- REQ-005 DIN_VALID  input  1  DIN holds a new pattern this cycle.
- REQ-006 DIN_READY  output  1  block can accept a pattern this cycle.
- REQ-007 BRIGHT  input  8  brightness level, sampled only at PWM period boundaries.
- REQ-008 LED0..LED7  output  1 each  dimmed pattern outputs, registered.

Function
- REQ-009 Prescaler: N-bit free-running counter; tick asserted for one CLK when it wraps; with N=0 tick is constant 1.
- REQ-010 PWM counter: 8 bits, increments on tick, wraps 255->0; the cycle on which it wraps 255->0 with tick high is the period boundary (PB).
- REQ-011 Registers: PEND[7:0] (accepted, not yet shown), SHOW[7:0] (displayed), LVL[7:0] (active brightness).
- REQ-012 FSM states: IDLE, HOLD.
- REQ-013 IDLE: DIN_READY=1; DIN_VALID=1 -> PEND<=DIN, next HOLD.
- REQ-014 HOLD: DIN_READY=0; DIN ignored; on PB -> SHOW<=PEND, next IDLE.
- REQ-015 On every PB (either state): LVL<=effective brightness of BRIGHT (REQ-024/025).
- REQ-016 Accept in IDLE on the same cycle as a PB: the PB reloads only LVL; the new word waits for the next PB.
- REQ-017 LEDi registered: LEDi <= SHOW[i] AND (LVL==255 OR PWM < LVL).
- REQ-018 LVL=0: all LEDs constantly 0; LVL=255: LEDs equal SHOW constantly, no off slot.
- REQ-019 Duty for 0<LVL<255: exactly LVL PWM slots of 256 on per period, on-slots contiguous from slot 0.
- REQ-020 Latency: a word accepted in IDLE appears on LEDs 1 CLK after the first subsequent PB; max 256*2^N+1 CLK.
- REQ-021 SHOW and LVL change only at PB; no partial-period glitch on LEDs.
- REQ-022 Words presented while DIN_READY=0 are dropped; upstream holds or discards, no backpressure beyond DIN_READY.

Reset
- REQ-023 RST=1 on a rising edge: prescaler=0, PWM=0, PEND=0, SHOW=0, LVL=0, state=IDLE, LED0..7=0, DIN_READY=1 on the first cycle after RST deasserts; RST mid-HOLD discards PEND; RST dominates DIN_VALID.

Configuration
- REQ-024 Macro LED_DIMMER_GAMMA_EN defined: effective brightness = (BRIGHT*BRIGHT)>>8, except BRIGHT=255 -> 255.
- REQ-025 Macro LED_DIMMER_GAMMA_EN undefined: effective brightness = BRIGHT unchanged; no multiplier logic present.

Verification
- REQ-026 N=0, RST 3 cycles, release -> LEDs all 0, DIN_READY=1, DIN_READY stays 1 with DIN_VALID=0 for 600 cycles.
- REQ-027 N=0, BRIGHT=255, DIN=0xA5 valid 1 cycle -> DIN_READY=0 until PB; 1 CLK after PB LEDs=0xA5 constant; DIN_READY=1 again.
- REQ-028 N=0, BRIGHT=64, gamma off, SHOW=0xFF -> each LED high exactly 64 of 256 cycles per period, high at PWM 0..63.
- REQ-029 N=2, DIN=0x0F then DIN=0xF0 while HOLD -> 0xF0 dropped, LEDs show 0x0F only; PB spacing 1024 CLK.
- REQ-030 BRIGHT changed 0->200 mid-period -> duty unchanged until next PB, then 200/256 (gamma off) or 156/256 (gamma on).
- REQ-031 RST asserted during HOLD with PEND=0x3C -> LEDs 0, state IDLE, 0x3C never displayed.
